// File: rtl/wb_pkg.sv
// Shared types and default sizes for the writeback register file slice.
package wb_pkg;

   localparam int WB_NUM_REGS = 16;
   localparam int WB_DATA_W   = 32;
   localparam int WB_REG_W    = $clog2(WB_NUM_REGS);

   typedef logic [WB_REG_W-1:0]    reg_t;
   typedef logic [WB_DATA_W-1:0]   imm_t;
   typedef logic [WB_NUM_REGS-1:0] scoreboard_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: busy vector, issue stall and pending-write count.
// REGFILE_BYPASS_EN: a register committing this cycle no longer stalls issue.
module wb_scoreboard
   import wb_pkg::*;
#(
   parameter int NUM_REGS = WB_NUM_REGS,
   parameter int REG_W    = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic             wb_wr,
   input  logic [REG_W-1:0] reg_dst,
   input  logic             issue_valid,
   input  logic             issue_wr,
   input  logic [REG_W-1:0] issue_dst,
   input  logic             issue_use1,
   input  logic [REG_W-1:0] issue_src1,
   input  logic             issue_use2,
   input  logic [REG_W-1:0] issue_src2,
   output logic             stall,
   output logic [REG_W:0]   pending_cnt
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_eff;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [REG_W:0]      cnt_q;

   function automatic logic [REG_W:0] popcount(input logic [NUM_REGS-1:0] v);
      logic [REG_W:0] c;
      c = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         c = c + {{REG_W{1'b0}}, v[i]};
      end
      return c;
   endfunction

   always_comb begin
      busy_eff = busy_q;
`ifdef REGFILE_BYPASS_EN
      if (wb_wr) begin
         busy_eff[reg_dst] = 1'b0;
      end
`endif
   end

   assign stall = issue_valid & ((issue_use1 & busy_eff[issue_src1]) |
                                 (issue_use2 & busy_eff[issue_src2]) |
                                 (issue_wr   & busy_eff[issue_dst]));

   // Set is applied after clear so an accepted issue wins over a same-register commit.
   always_comb begin
      busy_nxt = busy_q;
      if (wb_wr) begin
         busy_nxt[reg_dst] = 1'b0;
      end
      if (issue_valid && !stall && issue_wr && (issue_dst != '0)) begin
         busy_nxt[issue_dst] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!arstn) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_nxt;
         cnt_q  <= popcount(busy_nxt);
      end
   end

   assign pending_cnt = cnt_q;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file with ALU writeback, two read ports and hazard stall.
// REGFILE_BYPASS_EN: forward the committing ALU result to the read ports.
module wb_regfile
   import wb_pkg::*;
#(
   parameter int NUM_REGS = WB_NUM_REGS,
   parameter int DATA_W   = WB_DATA_W,
   parameter int REG_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              arstn,
   input  logic              wb_wr_i,
   input  logic [REG_W-1:0]  reg_dst_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              issue_valid_i,
   input  logic              issue_wr_i,
   input  logic [REG_W-1:0]  issue_dst_i,
   input  logic              issue_use1_i,
   input  logic [REG_W-1:0]  issue_src1_i,
   input  logic              issue_use2_i,
   input  logic [REG_W-1:0]  issue_src2_i,
   output logic [DATA_W-1:0] rd1_data_o,
   output logic [DATA_W-1:0] rd2_data_o,
   output logic              stall_o,
   output logic [REG_W:0]    pending_cnt_o
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!arstn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_wr_i && (reg_dst_i != '0)) begin
         regs[reg_dst_i] <= wb_data_i;
      end
   end

   always_comb begin
      rd1_data_o = (issue_src1_i == '0) ? '0 : regs[issue_src1_i];
      rd2_data_o = (issue_src2_i == '0) ? '0 : regs[issue_src2_i];
`ifdef REGFILE_BYPASS_EN
      if (wb_wr_i && (reg_dst_i != '0) && (reg_dst_i == issue_src1_i)) begin
         rd1_data_o = wb_data_i;
      end
      if (wb_wr_i && (reg_dst_i != '0) && (reg_dst_i == issue_src2_i)) begin
         rd2_data_o = wb_data_i;
      end
`endif
   end

   wb_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .REG_W    (REG_W)
   ) u_scoreboard (
      .clk         (clk),
      .arstn       (arstn),
      .wb_wr       (wb_wr_i),
      .reg_dst     (reg_dst_i),
      .issue_valid (issue_valid_i),
      .issue_wr    (issue_wr_i),
      .issue_dst   (issue_dst_i),
      .issue_use1  (issue_use1_i),
      .issue_src1  (issue_src1_i),
      .issue_use2  (issue_use2_i),
      .issue_src2  (issue_src2_i),
      .stall       (stall_o),
      .pending_cnt (pending_cnt_o)
   );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus random traffic against a behavioural model.
module tb_wb_regfile;

   localparam int NR = 16;
   localparam int DW = 32;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          arstn;
   logic          wb_wr_i;
   logic [RW-1:0] reg_dst_i;
   logic [DW-1:0] wb_data_i;
   logic          issue_valid_i;
   logic          issue_wr_i;
   logic [RW-1:0] issue_dst_i;
   logic          issue_use1_i;
   logic [RW-1:0] issue_src1_i;
   logic          issue_use2_i;
   logic [RW-1:0] issue_src2_i;
   logic [DW-1:0] rd1_data_o;
   logic [DW-1:0] rd2_data_o;
   logic          stall_o;
   logic [RW:0]   pending_cnt_o;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk           (clk),
      .arstn         (arstn),
      .wb_wr_i       (wb_wr_i),
      .reg_dst_i     (reg_dst_i),
      .wb_data_i     (wb_data_i),
      .issue_valid_i (issue_valid_i),
      .issue_wr_i    (issue_wr_i),
      .issue_dst_i   (issue_dst_i),
      .issue_use1_i  (issue_use1_i),
      .issue_src1_i  (issue_src1_i),
      .issue_use2_i  (issue_use2_i),
      .issue_src2_i  (issue_src2_i),
      .rd1_data_o    (rd1_data_o),
      .rd2_data_o    (rd2_data_o),
      .stall_o       (stall_o),
      .pending_cnt_o (pending_cnt_o)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: architectural values and set of registers awaiting a write.
   logic [DW-1:0] m_regs [NR];
   bit            m_busy [NR];
   bit            m_ready = 1'b0;

   function automatic bit m_beff(input int r, input bit wr, input int rd);
      if (r == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (wr && rd == r) return 1'b0;
`endif
      return m_busy[r];
   endfunction

   function automatic logic [DW-1:0] m_read(input int r, input bit wr, input int rd,
                                            input logic [DW-1:0] wd);
      if (r == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (wr && rd == r) return wd;
`endif
      return m_regs[r];
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < NR; i++) c += m_busy[i];
      return c;
   endfunction

   logic [DW-1:0] obs_rd1, obs_rd2;
   logic          obs_stall;
   logic [RW:0]   obs_pend;

   task automatic cycle(input bit rn, input bit wr, input int rd, input logic [DW-1:0] wd,
                        input bit iv, input bit iw, input int idst,
                        input bit u1, input int s1, input bit u2, input int s2);
      bit exp_stall;
      arstn         = rn;
      wb_wr_i       = wr;
      reg_dst_i     = RW'(rd);
      wb_data_i     = wd;
      issue_valid_i = iv;
      issue_wr_i    = iw;
      issue_dst_i   = RW'(idst);
      issue_use1_i  = u1;
      issue_src1_i  = RW'(s1);
      issue_use2_i  = u2;
      issue_src2_i  = RW'(s2);
      #3;
      exp_stall = iv && ((u1 && m_beff(s1, wr, rd)) || (u2 && m_beff(s2, wr, rd)) ||
                         (iw && m_beff(idst, wr, rd)));
      obs_rd1   = rd1_data_o;
      obs_rd2   = rd2_data_o;
      obs_stall = stall_o;
      obs_pend  = pending_cnt_o;
      if (m_ready) begin
         check("rd1",   64'(obs_rd1),   64'(m_read(s1, wr, rd, wd)));
         check("rd2",   64'(obs_rd2),   64'(m_read(s2, wr, rd, wd)));
         check("stall", 64'(obs_stall), 64'(exp_stall));
         check("pend",  64'(obs_pend),  64'(m_count()));
      end
      @(posedge clk);
      if (!rn) begin
         for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
         m_ready = 1'b1;
      end else if (m_ready) begin
         if (wr && rd != 0) m_regs[rd] = wd;
         if (wr) m_busy[rd] = 1'b0;
         if (iv && !exp_stall && iw && idst != 0) m_busy[idst] = 1'b1;
      end
      #1;
   endtask

   task automatic idle(input int s1, input int s2);
      cycle(1, 0, 0, '0, 0, 0, 0, 0, s1, 0, s2);
   endtask

   initial begin
      // Reset and R0 write
      cycle(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 0, 32'hDEAD, 0, 0, 0, 1, 0, 0, 0);
      idle(0, 0);
      check("r0_read", 64'(obs_rd1), 64'h0);
      check("r0_pend", 64'(obs_pend), 64'h0);
      check("r0_stall", 64'(obs_stall), 64'h0);

      // Write then read
      cycle(1, 1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, '0, 1, 0, 0, 1, 3, 0, 0);
      check("wr_rd", 64'(obs_rd1), 64'h12345678);
      check("wr_rd_stall", 64'(obs_stall), 64'h0);

      // RAW
      cycle(1, 0, 0, '0, 1, 1, 5, 0, 0, 0, 0);
      cycle(1, 0, 0, '0, 1, 0, 0, 1, 5, 0, 0);
      check("raw_pend", 64'(obs_pend), 64'd1);
      check("raw_stall", 64'(obs_stall), 64'h1);
      cycle(1, 1, 5, 32'hA5, 1, 0, 0, 1, 5, 0, 0);
`ifdef REGFILE_BYPASS_EN
      check("raw_wb_stall", 64'(obs_stall), 64'h0);
      check("raw_wb_fwd", 64'(obs_rd1), 64'hA5);
`else
      check("raw_wb_stall", 64'(obs_stall), 64'h1);
`endif
      cycle(1, 0, 0, '0, 1, 0, 0, 1, 5, 0, 0);
      check("raw_after_stall", 64'(obs_stall), 64'h0);
      check("raw_after_rd", 64'(obs_rd1), 64'hA5);

      // WAW
      cycle(1, 0, 0, '0, 1, 1, 7, 0, 0, 0, 0);
      cycle(1, 0, 0, '0, 1, 1, 7, 0, 0, 0, 0);
      check("waw_stall", 64'(obs_stall), 64'h1);
      check("waw_pend", 64'(obs_pend), 64'd1);
      idle(0, 0);
      check("waw_pend_after", 64'(obs_pend), 64'd1);

      // Simultaneous set and clear on R2
      cycle(1, 0, 0, '0, 1, 1, 2, 0, 0, 0, 0);
      cycle(1, 1, 2, 32'h1, 1, 1, 2, 0, 0, 0, 0);
`ifdef REGFILE_BYPASS_EN
      check("sc_stall", 64'(obs_stall), 64'h0);
`else
      check("sc_stall", 64'(obs_stall), 64'h1);
`endif
      idle(2, 0);
      check("sc_data", 64'(obs_rd1), 64'h1);
`ifdef REGFILE_BYPASS_EN
      check("sc_pend", 64'(obs_pend), 64'd2);
`else
      check("sc_pend", 64'(obs_pend), 64'd1);
`endif

      // Reset mid-operation
      cycle(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, '0, 1, 1, 4, 0, 0, 0, 0);
      cycle(1, 0, 0, '0, 1, 1, 6, 0, 0, 0, 0);
      idle(0, 0);
      check("mid_pend_before", 64'(obs_pend), 64'd2);
      cycle(0, 1, 4, 32'h9, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, '0, 1, 0, 0, 1, 4, 1, 6);
      check("mid_r4", 64'(obs_rd1), 64'h0);
      check("mid_pend", 64'(obs_pend), 64'h0);
      check("mid_stall", 64'(obs_stall), 64'h0);

      // Random traffic, indices biased low to provoke hazards
      for (int n = 0; n < 800; n++) begin
         cycle($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 7)),
               $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
               $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
